// File: rtl/msi_cpu_ctrl.sv
// Processor-side MSI coherence controller for a single cache block.
// Turns CPU requests into bus ops, sequences dirty write-back, and tracks coherence state under snoops.
module msi_cpu_ctrl #(
  parameter logic [1:0] STATE_INIT = 2'b00,
  parameter int         MAX_WAIT   = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cpu_valid,
  input  logic       cpu_op,
  input  logic       cpu_hit,
  input  logic       snoop_inv,
  input  logic       snoop_share,
  input  logic       bus_gnt,
  input  logic       wb_ack,
  output logic       bus_req,
  output logic [1:0] bus_op,
  output logic       wb_req,
  output logic       cpu_done,
  output logic       busy,
  output logic [1:0] coh_state,
  output logic       gnt_timeout
);

  localparam logic [1:0] COH_I = 2'b00;
  localparam logic [1:0] COH_E = 2'b01;
  localparam logic [1:0] COH_S = 2'b10;

  localparam logic [1:0] OP_RM  = 2'b00;
  localparam logic [1:0] OP_INV = 2'b01;
  localparam logic [1:0] OP_WM  = 2'b10;

  localparam int              CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0]   WAIT_MAX = CW'(MAX_WAIT);

  // S_UPDATE is the cycle after the bus op issues: coherence state takes its target there,
  // and the completion pulse follows in S_DONE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_ARB,
    S_UPDATE,
    S_DONE
  } ctrl_e;

  ctrl_e         ctrl_q, ctrl_d;
  logic [1:0]    coh_q, coh_d;
  logic [1:0]    op_q, op_d;
  logic [1:0]    target_q, target_d;
  logic          bus_req_q, bus_req_d;
  logic          wb_req_q, wb_req_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;

  logic       snoop_any;
  logic [1:0] coh_snoop;
  logic       dec_hit;
  logic       dec_wb;
  logic [1:0] dec_op;
  logic [1:0] dec_target;

  assign snoop_any = snoop_inv | snoop_share;

  // Invalidate dominates share; share only demotes an Exclusive block.
  always_comb begin
    coh_snoop = coh_q;
    if (snoop_inv)                          coh_snoop = COH_I;
    else if (snoop_share && coh_q == COH_E) coh_snoop = COH_S;
  end

  always_comb begin
    dec_hit    = 1'b0;
    dec_wb     = 1'b0;
    dec_op     = cpu_op ? OP_WM : OP_RM;
    dec_target = cpu_op ? COH_E : COH_S;
    unique case (coh_snoop)
      COH_S: begin
        if (!cpu_op && cpu_hit)     dec_hit = 1'b1;
        else if (cpu_op && cpu_hit) dec_op  = OP_INV;
      end
      COH_E: begin
        if (cpu_hit) dec_hit = 1'b1;
        else         dec_wb  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl_d    = ctrl_q;
    coh_d     = coh_snoop;
    op_d      = op_q;
    target_d  = target_q;
    bus_req_d = bus_req_q;
    wb_req_d  = wb_req_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;

    unique case (ctrl_q)
      S_IDLE: begin
        if (cpu_valid) begin
          if (dec_hit) begin
            ctrl_d = S_DONE;
          end else begin
            op_d     = dec_op;
            target_d = dec_target;
            if (dec_wb) begin
              ctrl_d   = S_WB;
              wb_req_d = 1'b1;
            end else begin
              ctrl_d    = S_ARB;
              bus_req_d = 1'b1;
              wait_d    = '0;
            end
          end
        end
      end
      S_WB: begin
        if (wb_ack) begin
          ctrl_d    = S_ARB;
          wb_req_d  = 1'b0;
          bus_req_d = 1'b1;
          wait_d    = '0;
        end
      end
      S_ARB: begin
        if (snoop_inv && op_q == OP_INV) op_d = OP_WM;
        // A grant coinciding with a snoop is discarded; the request stays pending.
        if (bus_gnt && !snoop_any) begin
          ctrl_d    = S_UPDATE;
          bus_req_d = 1'b0;
          coh_d     = target_q;
        end else if (MAX_WAIT != 0) begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_MAX) timeout_d = 1'b1;
        end
      end
      S_UPDATE: ctrl_d = S_DONE;
      S_DONE:   ctrl_d = S_IDLE;
      default:  ctrl_d = S_IDLE;
    endcase

    done_d = (ctrl_d == S_DONE);
    busy_d = (ctrl_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ctrl_q    <= S_IDLE;
      coh_q     <= STATE_INIT;
      op_q      <= OP_RM;
      target_q  <= COH_I;
      bus_req_q <= 1'b0;
      wb_req_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      coh_q     <= coh_d;
      op_q      <= op_d;
      target_q  <= target_d;
      bus_req_q <= bus_req_d;
      wb_req_q  <= wb_req_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_op      = op_q;
  assign wb_req      = wb_req_q;
  assign cpu_done    = done_q;
  assign busy        = busy_q;
  assign coh_state   = coh_q;
  assign gnt_timeout = timeout_q;

endmodule
